vlc_bit_packer: RTL and testbench

Parametrised bitstream packer that merges the codeword streams of up to `NUM_CH` VLC sources into one byte-aligned output word stream. Sources are the DC coder, the AC run and AC level coders, and the header/slice writers. It replaces the single-source `set_bit` stage and the OR-merge of its inputs with per-channel valid/ready handshakes, fixed-priority arbitration, an output backpressure handshake, and a flush that pads to a byte boundary. It sits between the entropy coders and the slice memory writer.

---
 rtl/prores_bitpack_pkg.sv | 25 ++
 rtl/vlc_bit_arbiter.sv | 35 +++
 rtl/vlc_bit_packer.sv | 147 ++++++++++++++
 tb/tb_vlc_bit_packer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prores_bitpack_pkg.sv
// ============================================================
// Package  : prores_bitpack_pkg
// Brief    : shared state encoding, defaults and helpers for the VLC packer
// Revision : 1.0
// ============================================================
`default_nettype none

package prores_bitpack_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int DEF_NUM_CH        = 4;
    localparam int DEF_MAX_CODE_BITS = 32;
    localparam int DEF_OUT_BYTES     = 8;

    function automatic int ceil_bytes(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vlc_bit_arbiter.sv
// ============================================================
// Module   : vlc_bit_arbiter
// Brief    : lowest-index fixed-priority encoder, one-hot grant plus index
// Revision : 1.0
// ============================================================
`default_nettype none

module vlc_bit_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    // Scan from the top so the lowest requesting index is the last writer.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vlc_bit_packer.sv
// ============================================================
// Module   : vlc_bit_packer
// Brief    : merges NUM_CH VLC codeword streams into MSB-first output words
// Revision : 1.0
// ============================================================
`default_nettype none

module vlc_bit_packer
    import prores_bitpack_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int MAX_CODE_BITS = DEF_MAX_CODE_BITS,
    parameter int OUT_BYTES     = DEF_OUT_BYTES,
    parameter int SIZE_W        = $clog2(MAX_CODE_BITS + 1)
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic [NUM_CH-1:0]                       in_valid,
    input  logic [NUM_CH-1:0][MAX_CODE_BITS-1:0]    in_val,
    input  logic [NUM_CH-1:0][SIZE_W-1:0]           in_size,
    input  logic [NUM_CH-1:0]                       in_flush,
    output logic [NUM_CH-1:0]                       in_ready,
    output logic                                    out_valid,
    output logic [OUT_BYTES*8-1:0]                  out_data,
    output logic [$clog2(OUT_BYTES+1)-1:0]          out_byte_count,
    output logic                                    out_last,
    input  logic                                    out_ready,
    output logic [31:0]                             bit_count,
    output logic                                    busy
);

    localparam int W      = OUT_BYTES * 8;
    localparam int A      = W + MAX_CODE_BITS;
    localparam int FILL_W = $clog2(A + 1);
    localparam int BC_W   = $clog2(OUT_BYTES + 1);
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [FILL_W-1:0] c_word_bits = FILL_W'(W);
    localparam logic [FILL_W-1:0] c_acc_bits  = FILL_W'(A);
    localparam logic [SIZE_W-1:0] c_max_size  = SIZE_W'(MAX_CODE_BITS);

    state_t              r_state;
    logic [A-1:0]        r_acc;
    logic [FILL_W-1:0]   r_fill;
    logic [31:0]         r_bit_count;
    logic                r_active;

    logic [NUM_CH-1:0]        w_grant;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_any;
    logic                     w_room;
    logic                     w_accept;
    logic [MAX_CODE_BITS-1:0] w_sel_val;
    logic [SIZE_W-1:0]        w_sel_size;
    logic                     w_sel_flush;
    logic [SIZE_W-1:0]        w_size;
    logic [FILL_W-1:0]        w_size_f;
    logic [FILL_W-1:0]        w_mask_sh;
    logic [FILL_W-1:0]        w_ins_sh;
    logic [A-1:0]             w_mask;
    logic [A-1:0]             w_ins;
    logic [FILL_W-1:0]        w_fill_pop;
    logic                     w_full;
    logic                     w_out_valid;
    logic                     w_out_last;

    vlc_bit_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arbiter (
        .req   (in_valid),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    // r_active keeps in_ready low from the reset edge until the first clock after release.
    assign w_room   = (r_fill < c_word_bits);
    assign in_ready = (r_active && (r_state == RUN) && w_room) ? w_grant : '0;
    assign w_accept = w_any && r_active && (r_state == RUN) && w_room;

    assign w_sel_val   = in_val[w_idx];
    assign w_sel_size  = in_size[w_idx];
    assign w_sel_flush = in_flush[w_idx];
    assign w_size      = (w_sel_size > c_max_size) ? c_max_size : w_sel_size;
    assign w_size_f    = FILL_W'(w_size);

    // Codeword lands directly below the current fill; bits above its size are masked off.
    assign w_mask_sh = c_acc_bits - w_size_f;
    assign w_mask    = {A{1'b1}} >> w_mask_sh;
    assign w_ins_sh  = c_acc_bits - r_fill - w_size_f;
    assign w_ins     = ({{(A - MAX_CODE_BITS){1'b0}}, w_sel_val} & w_mask) << w_ins_sh;

    assign w_full      = (r_fill >= c_word_bits);
    assign w_fill_pop  = w_full ? (r_fill - c_word_bits) : '0;
    assign w_out_valid = w_full || ((r_state == FLUSH) && (r_fill != '0));
    assign w_out_last  = (r_state == FLUSH) && (r_fill <= c_word_bits) && w_out_valid;

    assign out_valid      = w_out_valid;
    assign out_last       = w_out_last;
    assign out_data       = r_acc[A-1 -: W];
    assign out_byte_count = w_full ? BC_W'(OUT_BYTES) : BC_W'(ceil_bytes(int'(r_fill)));
    assign bit_count      = r_bit_count;
    assign busy           = (r_fill != '0) || (r_state == FLUSH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_acc       <= '0;
            r_fill      <= '0;
            r_bit_count <= '0;
            r_active    <= 1'b0;
        end else begin
            r_active <= 1'b1;
            case (r_state)
                RUN: begin
                    if (w_accept) begin
                        r_acc       <= r_acc | w_ins;
                        r_fill      <= r_fill + w_size_f;
                        r_bit_count <= r_bit_count + 32'(w_size);
                        if (w_sel_flush) begin
                            r_state <= FLUSH;
                        end
                    end else if (w_out_valid && out_ready) begin
                        r_acc  <= r_acc << W;
                        r_fill <= w_fill_pop;
                    end
                end
                FLUSH: begin
                    if (r_fill == '0) begin
                        r_state <= RUN;
                    end else if (out_ready) begin
                        r_acc  <= r_acc << W;
                        r_fill <= w_fill_pop;
                        if (w_out_last) begin
                            r_state <= RUN;
                        end
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vlc_bit_packer.sv
// ============================================================
// Module   : tb_vlc_bit_packer
// Brief    : scoreboard bench for vlc_bit_packer with default parameters
// Revision : 1.0
// ============================================================
`default_nettype none

module tb_vlc_bit_packer;

    logic              clock;
    logic              reset_n;
    logic [3:0]        in_valid;
    logic [3:0][31:0]  in_val;
    logic [3:0][5:0]   in_size;
    logic [3:0]        in_flush;
    logic [3:0]        in_ready;
    logic              out_valid;
    logic [63:0]       out_data;
    logic [3:0]        out_byte_count;
    logic              out_last;
    logic              out_ready;
    logic [31:0]       bit_count;
    logic              busy;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  bc;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    vlc_bit_packer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_val         (in_val),
        .in_size        (in_size),
        .in_flush       (in_flush),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_byte_count (out_byte_count),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .bit_count      (bit_count),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output monitor: every handshaked word is popped from the scoreboard and compared.
    always begin
        exp_t e;
        @(negedge clock);
        #2;
        if (reset_n && out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL word_unexpected got data=%h bc=%0d last=%0b, none expected",
                         out_data, out_byte_count, out_last);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || out_byte_count !== e.bc || out_last !== e.last) begin
                    miscompares++;
                    $display("FAIL word got data=%h bc=%0d last=%0b, want data=%h bc=%0d last=%0b",
                             out_data, out_byte_count, out_last, e.data, e.bc, e.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Entered and left at a falling edge; drops valid after the accepting edge.
    task automatic send(input int ch, input logic [31:0] v, input logic [5:0] s, input logic f);
        int n;
        n = 0;
        in_valid[ch] = 1'b1;
        in_val[ch]   = v;
        in_size[ch]  = s;
        in_flush[ch] = f;
        #1;
        while (!in_ready[ch] && n < 40) begin
            @(negedge clock);
            #1;
            n++;
        end
        vectors++;
        if (!in_ready[ch]) begin
            miscompares++;
            $display("FAIL send_timeout ch%0d in_ready=%b, want ready within 40 cycles", ch, in_ready);
        end
        @(negedge clock);
        in_valid[ch] = 1'b0;
        in_flush[ch] = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            #3;
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        in_valid  = '0;
        in_flush  = '0;
        in_size   = '0;
        in_val    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n  = 1'b0;
        in_valid = 4'hF;
        in_size  = '0;
        repeat (2) @(negedge clock);
        #1;
        vectors++;
        if (in_ready !== 4'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got rdy=%b ov=%b last=%b busy=%b, want all 0",
                     in_ready, out_valid, out_last, busy);
        end
        vectors++;
        if (out_data !== 64'h0 || out_byte_count !== 4'd0 || bit_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data got data=%h bc=%0d bits=%0d, want 0 0 0",
                     out_data, out_byte_count, bit_count);
        end
        in_valid = '0;
        reset_n  = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_byte_stream();
        bit ok;
        do_reset();
        sb.push_back('{64'h0001020304050607, 4'd8, 1'b0});
        for (int i = 0; i < 8; i++) send(0, 32'(i), 6'd8, 1'b0);
        wait_idle(ok);
        vectors++;
        if (!ok || bit_count !== 32'd64 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL byte_stream got idle=%0b bits=%0d busy=%b, want 1 64 0", ok, bit_count, busy);
        end
    endtask

    task automatic test_flush_pad();
        bit ok;
        do_reset();
        sb.push_back('{64'hA000000000000000, 4'd1, 1'b1});
        send(1, 32'b101, 6'd3, 1'b1);
        wait_idle(ok);
        vectors++;
        if (!ok || bit_count !== 32'd3 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_pad got idle=%0b bits=%0d busy=%b, want 1 3 0", ok, bit_count, busy);
        end
    endtask

    task automatic test_priority();
        bit ok;
        do_reset();
        in_valid[0] = 1'b1; in_val[0] = 32'h1; in_size[0] = 6'd4;
        in_valid[2] = 1'b1; in_val[2] = 32'h2; in_size[2] = 6'd4;
        #1;
        vectors++;
        if (in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL prio_first got in_ready=%b, want 0001", in_ready);
        end
        @(negedge clock);
        in_valid[0] = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL prio_second got in_ready=%b, want 0100", in_ready);
        end
        @(negedge clock);
        in_valid[2] = 1'b0;
        sb.push_back('{64'h1200000000000000, 4'd1, 1'b1});
        send(1, 32'h0, 6'd0, 1'b1);
        wait_idle(ok);
        vectors++;
        if (!ok || bit_count !== 32'd8) begin
            miscompares++;
            $display("FAIL prio_bits got idle=%0b bits=%0d, want 1 8", ok, bit_count);
        end
    endtask

    task automatic test_boundary_cross();
        bit ok;
        do_reset();
        sb.push_back('{64'h000000000000000F, 4'd8, 1'b0});
        sb.push_back('{64'hF000000000000000, 4'd1, 1'b1});
        send(0, 32'h0, 6'd30, 1'b0);
        send(0, 32'h0, 6'd30, 1'b0);
        send(0, 32'hFF, 6'd8, 1'b0);
        send(0, 32'h0, 6'd0, 1'b1);
        wait_idle(ok);
        vectors++;
        if (!ok || bit_count !== 32'd68) begin
            miscompares++;
            $display("FAIL boundary_bits got idle=%0b bits=%0d, want 1 68", ok, bit_count);
        end
    endtask

    task automatic test_clamp();
        bit ok;
        do_reset();
        sb.push_back('{64'hDEADBEEF00000000, 4'd4, 1'b1});
        send(3, 32'hDEADBEEF, 6'd40, 1'b1);
        wait_idle(ok);
        vectors++;
        if (!ok || bit_count !== 32'd32) begin
            miscompares++;
            $display("FAIL clamp_bits got idle=%0b bits=%0d, want 1 32", ok, bit_count);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(0, 32'(8'h10 + i), 6'd8, 1'b0);
        in_valid[0] = 1'b1; in_size[0] = 6'd0; in_flush[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #2;
            vectors++;
            if (in_ready !== 4'b0 || out_valid !== 1'b1 || out_data !== 64'h1011121314151617 ||
                out_byte_count !== 4'd8 || out_last !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure c%0d got rdy=%b ov=%b data=%h bc=%0d last=%b, want 0000 1 1011121314151617 8 0",
                         c, in_ready, out_valid, out_data, out_byte_count, out_last);
            end
        end
        sb.push_back('{64'h1011121314151617, 4'd8, 1'b0});
        @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
        #2;
        vectors++;
        if (in_ready !== 4'b0001 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release got rdy=%b ov=%b, want 0001 0", in_ready, out_valid);
        end
        in_valid[0] = 1'b0;
        wait_idle(ok);
        vectors++;
        if (!ok || bit_count !== 32'd64) begin
            miscompares++;
            $display("FAIL bp_bits got idle=%0b bits=%0d, want 1 64", ok, bit_count);
        end
    endtask

    task automatic test_reset_mid_flush();
        bit ok;
        do_reset();
        out_ready = 1'b0;
        send(0, 32'hAB, 6'd8, 1'b1);
        #2;
        vectors++;
        if (out_last !== 1'b1 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midflush_pending got last=%b ov=%b, want 1 1", out_last, out_valid);
        end
        reset_n     = 1'b0;
        in_valid[0] = 1'b1;
        in_size[0]  = 6'd0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || bit_count !== 32'd0 || in_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL midflush_reset got ov=%b busy=%b bits=%0d rdy=%b, want 0 0 0 0000",
                     out_valid, busy, bit_count, in_ready);
        end
        @(negedge clock);
        in_valid[0] = 1'b0;
        reset_n     = 1'b1;
        out_ready   = 1'b1;
        @(negedge clock);
        sb.push_back('{64'h5000000000000000, 4'd1, 1'b1});
        send(0, 32'h5, 6'd4, 1'b1);
        wait_idle(ok);
        vectors++;
        if (!ok || bit_count !== 32'd4) begin
            miscompares++;
            $display("FAIL midflush_resume got idle=%0b bits=%0d, want 1 4", ok, bit_count);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = '0;
        in_val    = '0;
        in_size   = '0;
        in_flush  = '0;
        out_ready = 1'b1;

        test_reset();
        test_byte_stream();
        test_flush_pad();
        test_priority();
        test_boundary_cross();
        test_clamp();
        test_backpressure();
        test_reset_mid_flush();

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d words outstanding, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
